// File: rtl/nx_bit_count_pkg.sv
// Shared types and sizing helpers for the nx_bit_count bit-scan/bit-count unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nx_bit_count_pkg;

    // Operation selector carried with each operand.
    typedef enum logic [1:0] {
        CLZ    = 2'd0,
        CTZ    = 2'd1,
        CLO    = 2'd2,
        POPCNT = 2'd3
    } mode_t;

    // Number of SECT_SIZE-bit sections needed to cover a WIDTH-bit operand.
    function automatic int num_sects(input int width, input int sect_size);
        return (width + sect_size - 1) / sect_size;
    endfunction

    // Width of a per-section count (0..SECT_SIZE inclusive).
    function automatic int sect_cnt_w(input int sect_size);
        return $clog2(sect_size) + 1;
    endfunction

endpackage

// File: rtl/nx_bit_count_sect.sv
// One section of the stage-1 counter: trailing zeros, any-one flag and popcount.
// Latency: combinational.
// Backpressure: n/a.
// Ports: data (SECT_SIZE bits in); tz trailing-zero count, active (section has a 1),
//        pop population count (all sect_cnt_w(SECT_SIZE) bits out).
module nx_bit_count_sect
    import nx_bit_count_pkg::*;
#(
    parameter int SECT_SIZE = 8,
    localparam int CW       = sect_cnt_w(SECT_SIZE)
) (
    input  logic [SECT_SIZE-1:0] data,
    output logic [CW-1:0]        tz,
    output logic                 active,
    output logic [CW-1:0]        pop
);

    // Walking from the top down leaves tz at the lowest set bit; an all-zero
    // section keeps the SECT_SIZE default.
    always_comb begin
        tz = CW'(SECT_SIZE);
        for (int i = SECT_SIZE - 1; i >= 0; i--) begin
            if (data[i]) tz = CW'(i);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SECT_SIZE; i++) begin
            pop = pop + CW'(data[i]);
        end
    end

    assign active = |data;

endmodule

// File: rtl/nx_bit_count.sv
// Two-stage pipelined CLZ/CTZ/CLO/POPCNT unit with a pass-through tag.
// Latency: 2 cycles from accept to o_valid; one result per cycle when i_ready stays high.
// Backpressure: stalled results hold; o_ready = !s1_valid || s2_can_load (combinational from i_ready).
// Ports: i_clk, i_rst (async active-high); input side i_data/i_mode/i_tag/i_valid/o_ready;
//        output side o_count/o_full/o_tag/o_valid/i_ready.
module nx_bit_count
    import nx_bit_count_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SECT_SIZE   = 8,
    parameter int TAG_WIDTH   = 4,
    parameter int COUNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_data,
    input  mode_t                  i_mode,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_full,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic                   o_valid,
    input  logic                   i_ready
);

    localparam int NS  = num_sects(WIDTH, SECT_SIZE);
    localparam int PW  = NS * SECT_SIZE;
    localparam int SCW = sect_cnt_w(SECT_SIZE);

    // ---------------- handshake control ----------------
    logic s1_valid;
    logic s2_can_load;

    assign s2_can_load = !o_valid || i_ready;
    assign o_ready     = !s1_valid || s2_can_load;

    // ---------------- stage 1: conditioning ----------------
    // After conditioning every mode is "count zeros from bit 0 upward"
    // (POPCNT just counts ones of the raw data).
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] cond;
    logic [PW-1:0]    padded;

    always_comb begin
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = i_data[WIDTH-1-i];
        end
    end

    always_comb begin
        case (i_mode)
            CLZ:     cond = rev;
            CLO:     cond = ~rev;
            default: cond = i_data;
        endcase
        // Pad bits are 1 for scans so a scan never runs past WIDTH,
        // and 0 for POPCNT so they add nothing.
        padded             = {PW{i_mode != POPCNT}};
        padded[WIDTH-1:0]  = cond;
    end

    logic [NS-1:0][SCW-1:0] sect_tz;
    logic [NS-1:0][SCW-1:0] sect_pop;
    logic [NS-1:0]          sect_act;

    for (genvar g = 0; g < NS; g++) begin : g_sect
        nx_bit_count_sect #(.SECT_SIZE(SECT_SIZE)) u_sect (
            .data   (padded[g*SECT_SIZE +: SECT_SIZE]),
            .tz     (sect_tz[g]),
            .active (sect_act[g]),
            .pop    (sect_pop[g])
        );
    end

    // ---------------- stage 1 registers ----------------
    logic [NS-1:0][SCW-1:0] s1_tz;
    logic [NS-1:0][SCW-1:0] s1_pop;
    logic [NS-1:0]          s1_act;
    mode_t                  s1_mode;
    logic [TAG_WIDTH-1:0]   s1_tag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_tz    <= '0;
            s1_pop   <= '0;
            s1_act   <= '0;
            s1_mode  <= CLZ;
            s1_tag   <= '0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_tz   <= sect_tz;
                s1_pop  <= sect_pop;
                s1_act  <= sect_act;
                s1_mode <= i_mode;
                s1_tag  <= i_tag;
            end
        end
    end

    // ---------------- stage 2: summation ----------------
    logic [COUNT_WIDTH-1:0] sum;
    logic                   done;

    always_comb begin
        sum  = '0;
        done = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (s1_mode == POPCNT) begin
                sum = sum + COUNT_WIDTH'(s1_pop[k]);
            end else if (!done) begin
                // The first section holding a 1 ends the scan, its own
                // trailing zeros included.
                sum  = sum + COUNT_WIDTH'(s1_tz[k]);
                done = s1_act[k];
            end
        end
        // Guard only: padding already bounds every sum to WIDTH.
        if (sum > COUNT_WIDTH'(WIDTH)) sum = COUNT_WIDTH'(WIDTH);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_count <= '0;
            o_full  <= 1'b0;
            o_tag   <= '0;
        end else if (s2_can_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_count <= sum;
                o_full  <= (sum == COUNT_WIDTH'(WIDTH));
                o_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: doc/nx_bit_count.md
Name: nx_bit_count

Overview:
- Pipelined, parametrised bit-scan and bit-count unit. Generalises the combinational leading-zero counter.
- Four selectable modes per transaction: count leading zeros, count trailing zeros, count leading ones, and population count.
- Two-stage pipeline with valid/ready handshakes on input and output, plus a pass-through tag.
- Sits between operand-issue and result-writeback paths in the node ALU, where backpressure from writeback must be honoured.

Parameters:
- WIDTH, 32, operand width in bits (>= 1).
- SECT_SIZE, 8, bits per section counted in stage 1; must be a power of two, >= 2.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operand.
- COUNT_WIDTH, $clog2(WIDTH)+1, result width; must be able to represent the value WIDTH.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_data  input  WIDTH  operand
- i_mode  input  2  nx_bit_count_pkg::mode_t: CLZ=0, CTZ=1, CLO=2, POPCNT=3
- i_tag  input  TAG_WIDTH  opaque tag
- i_valid  input  1  input transaction valid
- o_ready  output  1  block can accept the input this cycle
- o_count  output  COUNT_WIDTH  result
- o_full  output  1  result == WIDTH (whole operand matched the scan/count condition)
- o_tag  output  TAG_WIDTH  tag of the result
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts the result

Behaviour:
- Reset (async assert, sync release): both stage-valid flags cleared; o_valid=0, o_count=0, o_full=0, o_tag=0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions; no partial result is ever presented.
- Handshakes:
  - An input is accepted when i_valid && o_ready.
  - A result is consumed when o_valid && i_ready.
  - o_valid, o_count, o_full and o_tag are registered and held stable while o_valid && !i_ready.
  - Inputs are don't-care when i_valid=0.
- Pipeline advance:
  - Stage 2 loads when it is empty or is being consumed this cycle.
  - Stage 1 loads when it is empty or is transferring into stage 2 this cycle.
  - o_ready = !s1_valid || s2_can_load. This is a combinational path from i_ready; it is permitted and documented.
  - Throughput is one result per cycle under continuous i_ready. Latency from acceptance to o_valid is exactly 2 cycles.
- Stage 1 (input conditioning and per-section counts, registered):
  - Conditioning by mode: CLZ uses bit-reversed data; CTZ uses data as-is; CLO uses bit-reversed, inverted data. After this step every scan counts zeros from index 0 upward.
  - Pad to NUM_SECTS*SECT_SIZE, where NUM_SECTS = ceil(WIDTH/SECT_SIZE).
  - Pad bits are 1 for scan modes, so a scan stops at WIDTH, and 0 for POPCNT.
  - Per section, register:
    - scan count: trailing zeros of the section, 0..SECT_SIZE;
    - active flag: section contains a 1;
    - popcount: 0..SECT_SIZE.
  - Register mode and tag with them.
- Stage 2 (summation, registered):
  - Scan modes: sum section counts from section 0 upward, stopping after the first active section inclusive.
  - POPCNT: sum all section popcounts.
  - Clamp to WIDTH. The clamp is a safety net only; it must be unreachable given the padding rule.
  - o_full = (result == WIDTH).
- Boundary behaviour:
  - WIDTH not a multiple of SECT_SIZE: the result must never exceed WIDTH and pad bits never contribute.
  - WIDTH < SECT_SIZE: NUM_SECTS=1, still correct.
  - Simultaneous accept and consume with both stages full: all stages shift, no bubble, no loss.
  - A stage-1 entry stalled behind a full, stalled stage 2 holds its contents unchanged.
- Widths: all sums are computed at COUNT_WIDTH bits. Section counts are $clog2(SECT_SIZE)+1 bits, zero-extended before summation.

Decomposition:
- Package nx_bit_count_pkg holds:
  - mode_t enum (2 bits): CLZ, CTZ, CLO, POPCNT;
  - localparam helpers for NUM_SECTS and section count width.
- Sub-module nx_bit_count_sect (combinational): input SECT_SIZE bits; outputs trailing-zero count, active flag and popcount. Instantiated NUM_SECTS times in stage 1.
- Top level holds conditioning, the two pipeline register stages, handshake control and summation.

Test Plan (defaults, WIDTH=32):
- Reset, then CLZ of 0x0001_0000 with tag 3, i_ready=1 -> o_valid exactly 2 cycles after accept; o_count=15, o_full=0, o_tag=3.
- Back-to-back CTZ 0x0000_0100, CLO 0xFF00_0000, POPCNT 0xF0F0_0001, CLZ 0x0000_0000, one per cycle -> results 8, 8, 9, 32 (o_full=1 only on the last), in order, no bubbles.
- Hold i_ready=0 while 3 inputs are offered -> two accepted, o_ready drops to 0, outputs stable. Release i_ready -> both results delivered in order, third input then accepted.
- WIDTH=12, SECT_SIZE=8: CLZ 0x000 -> 12, o_full=1; CTZ 0x800 -> 11; POPCNT 0xFFF -> 12; CLO 0xFFF -> 12.
- Assert i_rst with both stages full and o_valid=1 -> o_valid=0 and o_count=0 immediately (async). After release, o_ready=1 and no stale result appears.
- Random operands, modes and i_ready vs a reference model -> zero mismatches over 10k transactions; no result lost or duplicated.
